// File: rtl/note_detector.sv
// Tone receiver: measures the period of tone_in in clock_in cycles, classifies it as
// one of the notes do..si and flags the note once it has been stable for several periods.
module note_detector #(
  parameter logic [27:0] P_DO         = 28'd382219,
  parameter logic [27:0] P_RE         = 28'd340530,
  parameter logic [27:0] P_MI         = 28'd303370,
  parameter logic [27:0] P_FA         = 28'd286344,
  parameter logic [27:0] P_SOL        = 28'd255102,
  parameter logic [27:0] P_LA         = 28'd227272,
  parameter logic [27:0] P_SI         = 28'd202478,
  parameter int unsigned TOL_SHIFT    = 6,
  parameter int unsigned STABLE_COUNT = 4,
  parameter logic [27:0] MAX_PERIOD   = 28'd400000
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        tone_in,
  output logic [27:0] period_out,
  output logic        period_strobe,
  output logic [2:0]  note_code,
  output logic        note_valid
);

  localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] StableMax = CW'(STABLE_COUNT);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  // Window bounds fold to constants because p is always a parameter.
  function automatic logic in_win(input logic [27:0] per, input logic [27:0] p);
    return (per >= p - (p >> TOL_SHIFT)) && (per <= p + (p >> TOL_SHIFT));
  endfunction

  logic          sync1_q, sync2_q, sync3_q, rise_q;
  state_e        state_q, state_d;
  logic [27:0]   counter_q, counter_d;
  logic [27:0]   period_q, period_d;
  logic          strobe_q, strobe_d;
  logic [2:0]    code_q, code_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          timeout;
  logic [2:0]    cls;

  always_comb begin
    cls = 3'd0;
    if (in_win(period_q, P_DO))  cls = 3'd1;
    if (in_win(period_q, P_RE))  cls = 3'd2;
    if (in_win(period_q, P_MI))  cls = 3'd3;
    if (in_win(period_q, P_FA))  cls = 3'd4;
    if (in_win(period_q, P_SOL)) cls = 3'd5;
    if (in_win(period_q, P_LA))  cls = 3'd6;
    if (in_win(period_q, P_SI))  cls = 3'd7;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    period_d  = period_q;
    strobe_d  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      StIdle: begin
        counter_d = '0;
        if (rise_q) begin
          state_d   = StMeasure;
          counter_d = 28'd1;
        end
      end
      StMeasure: begin
        // A rise on the timeout cycle still counts as a valid period.
        if (rise_q) begin
          period_d  = counter_q;
          strobe_d  = 1'b1;
          counter_d = 28'd1;
        end else if (counter_q == MAX_PERIOD) begin
          state_d   = StIdle;
          counter_d = '0;
          period_d  = '0;
          timeout   = 1'b1;
        end else begin
          counter_d = counter_q + 28'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    count_d = count_q;
    valid_d = valid_q;
    if (timeout) begin
      code_d  = 3'd0;
      count_d = '0;
      valid_d = 1'b0;
    end else if (strobe_q) begin
      code_d = cls;
      if (cls == 3'd0) begin
        count_d = '0;
      end else if (cls == code_q) begin
        count_d = (count_q == StableMax) ? StableMax : count_q + CW'(1);
      end else begin
        count_d = CW'(1);
      end
      valid_d = (cls != 3'd0) && (count_d == StableMax);
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      rise_q    <= 1'b0;
      state_q   <= StIdle;
      counter_q <= '0;
      period_q  <= '0;
      strobe_q  <= 1'b0;
      code_q    <= 3'd0;
      count_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= tone_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      rise_q    <= sync2_q & ~sync3_q;
      state_q   <= state_d;
      counter_q <= counter_d;
      period_q  <= period_d;
      strobe_q  <= strobe_d;
      code_q    <= code_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
    end
  end

  assign period_out    = period_q;
  assign period_strobe = strobe_q;
  assign note_code     = code_q;
  assign note_valid    = valid_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector with periods scaled down by ~1000 so the run stays short.
module tb_note_detector;

  localparam logic [27:0] TP_DO  = 28'd382;
  localparam logic [27:0] TP_RE  = 28'd341;
  localparam logic [27:0] TP_MI  = 28'd303;
  localparam logic [27:0] TP_FA  = 28'd286;
  localparam logic [27:0] TP_SOL = 28'd255;
  localparam logic [27:0] TP_LA  = 28'd227;
  localparam logic [27:0] TP_SI  = 28'd202;
  localparam logic [27:0] TMAX   = 28'd400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tone_in = 1'b0;
  logic [27:0] period_out;
  logic        period_strobe;
  logic [2:0]  note_code;
  logic        note_valid;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int snap;
  logic [27:0] last_period = '0;
  logic strobe_prev = 1'b0;
  logic [2:0] code_log[$];
  logic valid_log[$];

  note_detector #(
    .P_DO(TP_DO), .P_RE(TP_RE), .P_MI(TP_MI), .P_FA(TP_FA), .P_SOL(TP_SOL),
    .P_LA(TP_LA), .P_SI(TP_SI), .TOL_SHIFT(6), .STABLE_COUNT(4), .MAX_PERIOD(TMAX)
  ) dut (
    .clock_in     (clk),
    .reset        (reset),
    .tone_in      (tone_in),
    .period_out   (period_out),
    .period_strobe(period_strobe),
    .note_code    (note_code),
    .note_valid   (note_valid)
  );

  always #5 clk = ~clk;

  // Log code/valid one cycle after each strobe, when the classification has landed.
  always @(negedge clk) begin
    if (strobe_prev) begin
      code_log.push_back(note_code);
      valid_log.push_back(note_valid);
    end
    strobe_prev = period_strobe;
    if (period_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_period = period_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    tone_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    code_log.delete();
    valid_log.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period_out), 0);
    check({tag, "_strobe"}, 32'(period_strobe), 0);
    check({tag, "_code"}, 32'(note_code), 0);
    check({tag, "_valid"}, 32'(note_valid), 0);
  endtask

  initial begin
    // T1: reset with tone toggling
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tone_in = ~tone_in;
      @(negedge clk);
    end
    check_zero("t1_reset");
    check("t1_no_strobe", 32'(strobe_cnt), 0);
    do_reset();

    // T2: la, 7 rises -> 6 measured periods
    snap = strobe_cnt;
    tone(227, 7);
    check("t2_strobes", 32'(strobe_cnt - snap), 6);
    check("t2_period", 32'(last_period), 227);
    check("t2_log_size", 32'(code_log.size()), 6);
    check("t2_code_first", 32'(code_log[0]), 6);
    check("t2_valid_3rd", 32'(valid_log[2]), 0);
    check("t2_valid_4th", 32'(valid_log[3]), 1);
    check("t2_code_end", 32'(note_code), 6);
    check("t2_valid_end", 32'(note_valid), 1);

    // T3: la then mi
    do_reset();
    tone(227, 6);
    tone(303, 6);
    check("t3_log_size", 32'(code_log.size()), 11);
    check("t3_la_valid", 32'(valid_log[5]), 1);
    check("t3_mi_code", 32'(code_log[6]), 3);
    check("t3_mi_drop", 32'(valid_log[6]), 0);
    check("t3_mi_3rd", 32'(valid_log[8]), 0);
    check("t3_mi_4th", 32'(valid_log[9]), 1);
    check("t3_period", 32'(last_period), 303);

    // T4: between sol and fa windows
    do_reset();
    tone(265, 4);
    check("t4_period", 32'(last_period), 265);
    check("t4_code", 32'(note_code), 0);
    check("t4_valid", 32'(note_valid), 0);

    // T5: timeout after stable la
    do_reset();
    tone(227, 6);
    repeat (100) @(negedge clk);
    check("t5_pre_code", 32'(note_code), 6);
    check("t5_pre_valid", 32'(note_valid), 1);
    repeat (100) @(negedge clk);
    check_zero("t5_timeout");
    snap = strobe_cnt;
    tone_in = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_first_rise_no_strobe", 32'(strobe_cnt - snap), 0);
    check("t5_period_still0", 32'(period_out), 0);
    tone_in = 1'b0;
    repeat (10) @(negedge clk);

    // T6: window edges and mid-period reset
    do_reset();
    tone(230, 5);
    check("t6_edge_in_period", 32'(last_period), 230);
    check("t6_edge_in_code", 32'(note_code), 6);
    do_reset();
    tone(231, 3);
    check("t6_edge_out_period", 32'(last_period), 231);
    check("t6_edge_out_code", 32'(note_code), 0);
    do_reset();
    tone(227, 5);
    check("t6_pre_valid", 32'(note_valid), 1);
    tone_in = 1'b1;
    repeat (50) @(negedge clk);
    snap = strobe_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_zero("t6_mid_reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_post_reset_no_strobe", 32'(strobe_cnt - snap), 0);
    check("t6_post_reset_period", 32'(period_out), 0);
    tone_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
